// File: rtl/mem_bridge_pkg.sv
// Shared types and helpers for the core-to-RAM bridge.
// States, write-size codes and the byte-count decode used by the lane aligner.
package mem_bridge_pkg;

   typedef enum logic [2:0] {
      RD_LO,
      RD_HI,
      RD_FIN,
      READY,
      WR_LO,
      WR_HI
   } state_t;

   localparam logic [1:0] WS_BYTE = 2'b00;
   localparam logic [1:0] WS_HALF = 2'b01;
   localparam logic [1:0] WS_WORD = 2'b10;
   localparam logic [1:0] WS_RSVD = 2'b11;

   // Reserved size decodes to zero bytes, so it yields an empty write mask.
   function automatic logic [2:0] size_bytes(input logic [1:0] ws);
      case (ws)
         WS_BYTE: return 3'd1;
         WS_HALF: return 3'd2;
         WS_WORD: return 3'd4;
         default: return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the core's byte-addressed view and two adjacent RAM words.
// Write side spreads data/mask over 8 lanes; read side extracts 4 bytes from {hi,lo}.
module mem_lane_align
   import mem_bridge_pkg::*;
(
   input  logic [1:0]  off,
   input  logic [1:0]  ws,
   input  logic [31:0] wr_data,
   input  logic [31:0] rd_lo,
   input  logic [31:0] rd_hi,
   output logic [7:0]  m8,
   output logic [63:0] d64,
   output logic [31:0] rd_data
);

   logic [7:0] base_mask;

   assign base_mask = (8'd1 << size_bytes(ws)) - 8'd1;
   assign m8        = base_mask << off;
   assign d64       = {32'b0, wr_data} << {off, 3'b000};
   assign rd_data   = 32'({rd_hi, rd_lo} >> {off, 3'b000});

endmodule

// File: rtl/mem_bridge.sv
// Bridge from the core's byte-addressed stall bus to a 32-bit synchronous RAM with byte enables.
// Unaligned accesses that straddle a word are split into a lo-word and a hi-word RAM access.
module mem_bridge
   import mem_bridge_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [31:0]       core_a,
   output logic [31:0]       core_i,
   input  logic [31:0]       core_o,
   input  logic              core_w,
   input  logic [1:0]        core_ws,
   output logic              core_ce,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   output logic [3:0]        ram_we,
   input  logic [31:0]       ram_rdata
);

   state_t              state, state_nx;
   logic [ADDR_W+1:0]   a_lat;
   logic [31:0]         lo, hi;
   logic [7:0]          m8_q;
   logic [63:0]         d64_q;
   logic [7:0]          m8;
   logic [63:0]         d64;
   logic [ADDR_W-1:0]   wa0, wa1;
   logic [1:0]          off;
   logic                unused_addr_bits;

   assign wa0 = a_lat[ADDR_W+1:2];
   assign wa1 = wa0 + ADDR_W'(1);
   assign off = a_lat[1:0];
   assign unused_addr_bits = ^core_a[31:ADDR_W+2];

   mem_lane_align u_align (
      .off     (off),
      .ws      (core_ws),
      .wr_data (core_o),
      .rd_lo   (lo),
      .rd_hi   (hi),
      .m8      (m8),
      .d64     (d64),
      .rd_data (core_i)
   );

   // NOTE: every register here is reset, including the data holding registers, so core_i reads 0 out of reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= RD_LO;
         a_lat <= '0;
         lo    <= '0;
         hi    <= '0;
         m8_q  <= '0;
         d64_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state <= state_nx;
         if (state == RD_LO)  a_lat <= core_a[ADDR_W+1:0];
         if (state == RD_HI)  lo    <= ram_rdata;
         if (state == RD_FIN) hi    <= ram_rdata;
         if (state == READY) begin
            m8_q  <= m8;
            d64_q <= d64;
         end
      end
   end

   always_comb begin
      // NOTE: defaults first so no path leaves an output unassigned (no latches).
      state_nx  = state;
      ram_addr  = wa0;
      ram_wdata = d64_q[31:0];
      ram_we    = 4'b0000;
      core_ce   = 1'b0;
      case (state)
         // core_a is stable while stalled, so it addresses the lo word before a_lat catches up.
         RD_LO: begin
            ram_addr = core_a[ADDR_W+1:2];
            state_nx = RD_HI;
         end
         RD_HI: begin
            ram_addr = wa1;
            state_nx = (off != 2'b00) ? RD_FIN : READY;
         end
         RD_FIN: begin
            ram_addr = wa1;
            state_nx = READY;
         end
         READY: begin
            core_ce  = 1'b1;
            state_nx = (core_w && core_ws != WS_RSVD) ? WR_LO : RD_LO;
         end
         WR_LO: begin
            ram_we   = m8_q[3:0];
            state_nx = (m8_q[7:4] != 4'b0000) ? WR_HI : RD_LO;
         end
         WR_HI: begin
            ram_addr  = wa1;
            ram_wdata = d64_q[63:32];
            ram_we    = m8_q[7:4];
            state_nx  = RD_LO;
         end
         default: state_nx = RD_LO;
      endcase
   end

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge: directed scenarios plus random accesses against a byte-array model.
// The model works on bytes a..a+sz-1 mod 1 KiB and derives expected RAM write cycles from them.
module tb_mem_bridge;
   import mem_bridge_pkg::*;

   localparam int NWORDS = 256;
   localparam int NBYTES = 1024;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] core_a, core_i, core_o;
   logic        core_w, core_ce;
   logic [1:0]  core_ws;
   logic [7:0]  ram_addr;
   logic [31:0] ram_wdata, ram_rdata;
   logic [3:0]  ram_we;

   always #5 clock = ~clock;

   mem_bridge #(.ADDR_W(8)) dut (
      .clock     (clock),
      .reset     (reset),
      .core_a    (core_a),
      .core_i    (core_i),
      .core_o    (core_o),
      .core_w    (core_w),
      .core_ws   (core_ws),
      .core_ce   (core_ce),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_we    (ram_we),
      .ram_rdata (ram_rdata)
   );

   // Synchronous RAM: one-cycle read latency, per-byte write enables.
   logic [31:0] init_mem [NWORDS];
   logic [31:0] ram      [NWORDS];
   logic        load_en;

   always @(posedge clock) begin
      if (load_en) begin
         for (int i = 0; i < NWORDS; i++) ram[i] <= init_mem[i];
      end else begin
         for (int b = 0; b < 4; b++)
            if (ram_we[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
      ram_rdata <= ram[ram_addr];
   end

   typedef struct packed {
      logic [7:0]  addr;
      logic [3:0]  we;
      logic [31:0] data;
   } wr_cyc_t;

   logic [7:0]  ref_mem  [NBYTES];
   logic [7:0]  ref_save [NBYTES];
   wr_cyc_t     exp_wr[$];
   wr_cyc_t     obs_wr[$];
   logic [7:0]  addr_hist[$];
   logic [31:0] last_rd;
   int          pend_wr;
   int          checks   = 0;
   int          failures = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int size_of(input logic [1:0] ws);
      return (ws == 2'd0) ? 1 : (ws == 2'd1) ? 2 : (ws == 2'd2) ? 4 : 0;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      logic [31:0] r;
      for (int k = 0; k < 4; k++) r[8*k +: 8] = ref_mem[int'((a + 32'(k)) & 32'h3FF)];
      return r;
   endfunction

   function automatic logic [31:0] lane_mask(input logic [3:0] we);
      logic [31:0] m;
      for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{we[b]}};
      return m;
   endfunction

   // Updates the byte model and queues the RAM write cycles the bridge must issue.
   task automatic model_write(input logic [31:0] a, input logic [1:0] ws, input logic [31:0] o,
                              input bit lo_only);
      wr_cyc_t    c [2];
      logic [7:0] w0;
      int         b, j, lane;
      w0   = a[9:2];
      c[0] = '{addr: w0,         we: 4'b0, data: 32'b0};
      c[1] = '{addr: w0 + 8'd1,  we: 4'b0, data: 32'b0};
      for (int k = 0; k < size_of(ws); k++) begin
         b    = int'((a + 32'(k)) & 32'h3FF);
         j    = ((b >> 2) == int'(w0)) ? 0 : 1;
         lane = b & 3;
         c[j].we[lane]          = 1'b1;
         c[j].data[8*lane +: 8] = o[8*k +: 8];
         if (!(lo_only && j == 1)) ref_mem[b] = o[8*k +: 8];
      end
      for (int i = 0; i < 2; i++) if (c[i].we != 4'b0) exp_wr.push_back(c[i]);
   endtask

   // One core transaction: read at a (always), optionally followed by a write to a.
   task automatic access(input logic [31:0] a, input logic w, input logic [1:0] ws,
                         input logic [31:0] o);
      int      n;
      int      exp_lat;
      bit      seen;
      wr_cyc_t oc;
      core_a = a; core_w = w; core_ws = ws; core_o = o;
      obs_wr.delete();
      addr_hist.delete();
      seen    = 0;
      n       = 0;
      exp_lat = pend_wr + ((a[1:0] != 2'b00) ? 4 : 3);
      while (!seen && n < 12) begin
         @(negedge clock);
         n++;
         if (ram_we != 4'b0) begin
            oc.addr = ram_addr;
            oc.we   = ram_we;
            oc.data = ram_wdata & lane_mask(ram_we);
            obs_wr.push_back(oc);
         end else begin
            addr_hist.push_back(ram_addr);
         end
         if (core_ce) seen = 1;
      end
      check("ce_latency", 64'(n), 64'(exp_lat));
      last_rd = core_i;
      check("core_i", core_i, model_read(a));
      check("wr_count", 64'(obs_wr.size()), 64'(exp_wr.size()));
      for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++)
         check("wr_cycle", 64'(obs_wr[i]), 64'(exp_wr[i]));
      exp_wr.delete();
      pend_wr = 0;
      if (w && ws != 2'b11) begin
         model_write(a, ws, o, 1'b0);
         pend_wr = exp_wr.size();
      end
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic [31:0] ra;
      for (int i = 0; i < NWORDS; i++) init_mem[i] = $urandom;
      init_mem[0]   = 32'h03020100;
      init_mem[1]   = 32'h07060504;
      init_mem[255] = 32'hFFEEDDCC;
      for (int i = 0; i < NBYTES; i++) ref_mem[i] = init_mem[i/4][8*(i%4) +: 8];

      reset = 1'b1; load_en = 1'b1;
      core_a = '0; core_o = '0; core_w = 1'b0; core_ws = 2'b00;
      pend_wr = 0;
      @(posedge clock); #1 load_en = 1'b0;
      @(negedge clock);
      check("reset_ce", core_ce, 1'b0);
      check("reset_we", ram_we, 4'b0);
      check("reset_core_i", core_i, 32'h0);
      @(posedge clock); #1 reset = 1'b0;

      access(32'h0, 1'b0, WS_BYTE, 32'h0);
      check("aligned_const", last_rd, 32'h03020100);

      access(32'h2, 1'b0, WS_BYTE, 32'h0);
      check("cross_const", last_rd, 32'h05040302);
      check("cross_addr0", addr_hist[0], 8'd0);
      check("cross_addr1", addr_hist[1], 8'd1);

      access(32'h3FE, 1'b0, WS_BYTE, 32'h0);
      check("wrap_const", last_rd, 32'h0100FFEE);
      check("wrap_addr0", addr_hist[0], 8'd255);
      check("wrap_addr1", addr_hist[1], 8'd0);

      access(32'h1, 1'b1, WS_BYTE, 32'h000000AA);
      access(32'h0, 1'b0, WS_BYTE, 32'h0);
      check("byte_we", obs_wr[0].we, 4'b0010);
      check("byte_reread", last_rd, 32'h0302AA00);

      access(32'h3, 1'b1, WS_WORD, 32'hDDCCBBAA);
      access(32'h0, 1'b0, WS_BYTE, 32'h0);
      check("xw_lo_we", obs_wr[0].we, 4'b1000);
      check("xw_hi_we", obs_wr[1].we, 4'b0111);
      check("xw_word0", last_rd, 32'hAA02AA00);
      access(32'h4, 1'b0, WS_BYTE, 32'h0);
      check("xw_word1", last_rd, 32'h07DDCCBB);

      access(32'h8, 1'b1, WS_RSVD, 32'hFFFFFFFF);
      access(32'h8, 1'b0, WS_BYTE, 32'h0);

      // Reset while the hi half of a split write is on the bus.
      ref_save = ref_mem;
      access(32'h3, 1'b1, WS_WORD, 32'h11223344);
      @(negedge clock);
      check("rst_wr_lo_we", ram_we, 4'b1000);
      @(posedge clock); #2;
      check("rst_wr_hi_we", ram_we, 4'b0111);
      reset = 1'b1;
      #1;
      check("rst_async_we", ram_we, 4'b0);
      check("rst_async_ce", core_ce, 1'b0);
      ref_mem = ref_save;
      exp_wr.delete();
      model_write(32'h3, WS_WORD, 32'h11223344, 1'b1);
      exp_wr.delete();
      pend_wr = 0;
      core_a = 32'h0;
      @(posedge clock);
      @(posedge clock); #1 reset = 1'b0;
      access(32'h0, 1'b0, WS_BYTE, 32'h0);
      access(32'h4, 1'b0, WS_BYTE, 32'h0);
      check("rst_word1_kept", last_rd, 32'h07DDCCBB);

      for (int t = 0; t < 300; t++) begin
         ra = 32'($urandom_range(0, NBYTES - 1));
         if ($urandom_range(0, 3) == 0) ra = ra | ($urandom & 32'hFFFFFC00);
         access(ra, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
      end
      access(32'h0, 1'b0, WS_BYTE, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
